ntt_butterfly_exec: RTL and testbench

//  Datapath consumer of the NTT address sequencer. Per valid beat it reads a butterfly pair (u,v)

---
 rtl/ntt_butterfly_exec.sv | 175 +++++++++++++++++
 tb/tb_ntt_butterfly_exec.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ntt_butterfly_exec : in-place radix-2 Cooley-Tukey butterfly executor       |
// | Optional NTT_EXEC_STATS_EN adds retired-butterfly counter bfly_cnt.         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ntt_butterfly_exec #(
  parameter int N_LOG = 3,
  parameter int N     = 8,
  parameter int W     = 16,
  parameter int Q     = 17,
  parameter int OMEGA = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N_LOG-1:0] in_addr_u,
  input  logic [N_LOG-1:0] in_addr_v,
  input  logic [N_LOG-1:0] in_addr_w,
  input  logic             in_done,
  input  logic             load_en,
  input  logic [N_LOG-1:0] load_addr,
  input  logic [W-1:0]     load_data,
  input  logic [N_LOG-1:0] rd_addr,
  output logic [W-1:0]     rd_data,
  output logic             busy,
  output logic             exec_done,
  output logic             load_err
`ifdef NTT_EXEC_STATS_EN
  ,
  output logic [2*N_LOG-1:0] bfly_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [W-1:0]   C_Q      = W'(Q);
  localparam logic [W:0]     C_Q_X    = (W+1)'(Q);
  localparam logic [2*W-1:0] C_Q_WIDE = (2*W)'(Q);

  function automatic logic [W-1:0] pow_mod(input int e);
    longint r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * OMEGA) % Q;
    return W'(r);
  endfunction

  // Full N-entry table keeps the index at N_LOG bits; valid schedules only use the lower half.
  logic [W-1:0] rom [N];
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rom
      assign rom[gi] = pow_mod(gi);
    end
  endgenerate

  logic [1:0]       r_state, w_next;
  logic [W-1:0]     r_ram [N];
  logic             r_e_valid;
  logic [W-1:0]     r_u, r_v, r_w;
  logic [N_LOG-1:0] r_addr_u, r_addr_v;
  logic             r_load_err;

  logic             w_accept, w_load;
  logic [W-1:0]     w_load_val;
  logic [2*W-1:0]   w_prod, w_t_full;
  logic [W-1:0]     w_t, w_u_new, w_v_new;
  logic [W:0]       w_sum, w_sum_red, w_v_alt;
  logic [W-1:0]     w_rd_u, w_rd_v;

  assign w_accept   = in_valid && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_load     = load_en && !busy;
  assign w_load_val = load_data % C_Q;

  // E2 butterfly on the registered operands; operands are always already reduced mod Q.
  assign w_prod    = {{W{1'b0}}, r_v} * {{W{1'b0}}, r_w};
  assign w_t_full  = w_prod % C_Q_WIDE;
  assign w_t       = w_t_full[W-1:0];
  assign w_sum     = {1'b0, r_u} + {1'b0, w_t};
  assign w_sum_red = w_sum - C_Q_X;
  assign w_u_new   = (w_sum >= C_Q_X) ? w_sum_red[W-1:0] : w_sum[W-1:0];
  assign w_v_alt   = {1'b0, r_u} + C_Q_X - {1'b0, w_t};
  assign w_v_new   = (r_u >= w_t) ? (r_u - w_t) : w_v_alt[W-1:0];

  // E1 read forwards the writeback retiring on the same edge.
  always_comb begin
    w_rd_u = r_ram[in_addr_u];
    if (r_e_valid && (in_addr_u == r_addr_v)) w_rd_u = w_v_new;
    if (r_e_valid && (in_addr_u == r_addr_u)) w_rd_u = w_u_new;
  end

  always_comb begin
    w_rd_v = r_ram[in_addr_v];
    if (r_e_valid && (in_addr_v == r_addr_u)) w_rd_v = w_u_new;
    if (r_e_valid && (in_addr_v == r_addr_v)) w_rd_v = w_v_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid <= 1'b0;
      r_u       <= '0;
      r_v       <= '0;
      r_w       <= '0;
      r_addr_u  <= '0;
      r_addr_v  <= '0;
    end else begin
      r_e_valid <= w_accept;
      if (w_accept) begin
        r_u      <= w_rd_u;
        r_v      <= w_rd_v;
        r_w      <= rom[in_addr_w];
        r_addr_u <= in_addr_u;
        r_addr_v <= in_addr_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_ram[i] <= '0;
    end else begin
      if (w_load) r_ram[load_addr] <= w_load_val;
      if (r_e_valid) begin
        r_ram[r_addr_u] <= w_u_new;
        r_ram[r_addr_v] <= w_v_new;
      end
    end
  end

  assign rd_data = r_ram[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)   w_next = S_RUN;
      S_RUN:   if (in_done)    w_next = S_FLUSH;
      S_FLUSH: if (!r_e_valid) w_next = S_DONE;
      S_DONE:  if (!in_done)   w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
    exec_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_load_err <= 1'b0;
    else if (load_en && busy)  r_load_err <= 1'b1;
  end

  assign load_err = r_load_err;

`ifdef NTT_EXEC_STATS_EN
  logic [2*N_LOG-1:0] r_bfly_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_bfly_cnt <= '0;
    else if ((r_state == S_IDLE) && (w_next == S_RUN)) r_bfly_cnt <= '0;
    else if (r_e_valid)                              r_bfly_cnt <= r_bfly_cnt + (2*N_LOG)'(1);
  end

  assign bfly_cnt = r_bfly_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ntt_butterfly_exec : directed bench for ntt_butterfly_exec               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_ntt_butterfly_exec;

  localparam int N_LOG = 3;
  localparam int N     = 8;
  localparam int W     = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [N_LOG-1:0] in_addr_u, in_addr_v, in_addr_w;
  logic             in_done;
  logic             load_en;
  logic [N_LOG-1:0] load_addr;
  logic [W-1:0]     load_data;
  logic [N_LOG-1:0] rd_addr;
  logic [W-1:0]     rd_data;
  logic             busy, exec_done, load_err;
`ifdef NTT_EXEC_STATS_EN
  logic [2*N_LOG-1:0] bfly_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  int vec_delta [N] = '{1, 0, 0, 0, 0, 0, 0, 0};
  int vec_ones  [N] = '{1, 1, 1, 1, 1, 1, 1, 1};
  int vec_dc    [N] = '{8, 0, 0, 0, 0, 0, 0, 0};
  int vec_zero  [N] = '{0, 0, 0, 0, 0, 0, 0, 0};

  ntt_butterfly_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_addr_u (in_addr_u),
    .in_addr_v (in_addr_v),
    .in_addr_w (in_addr_w),
    .in_done   (in_done),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .exec_done (exec_done),
    .load_err  (load_err)
`ifdef NTT_EXEC_STATS_EN
    ,
    .bfly_cnt  (bfly_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ram(input string tag, input int exp [N]);
    for (int i = 0; i < N; i++) begin
      rd_addr = N_LOG'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), 32'(rd_data), 32'(exp[i]));
    end
  endtask

  task automatic load(input int addr, input int data);
    load_en   = 1'b1;
    load_addr = N_LOG'(addr);
    load_data = W'(data);
    tick();
    load_en   = 1'b0;
  endtask

  task automatic load_vec(input int v [N]);
    for (int i = 0; i < N; i++) load(i, v[i]);
  endtask

  task automatic finish_run();
    int k;
    k = 0;
    in_done = 1'b1;
    while (!exec_done && k < 20) begin
      tick();
      k++;
    end
    chk("exec_done_rise", 32'(exec_done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    in_done = 1'b0;
    #1;
    chk("exec_done_hold", 32'(exec_done), 32'd1);
    tick();
    chk("exec_done_fall", 32'(exec_done), 32'd0);
  endtask

  // Bit-reversed-input DIT schedule; delta and all-ones inputs are bit-reversal invariant.
  task automatic run_ntt(input bit inject);
    int n;
    n = 0;
    for (int len = 2; len <= N; len *= 2)
      for (int st = 0; st < N; st += len)
        for (int j = 0; j < len / 2; j++) begin
          in_valid  = 1'b1;
          in_addr_u = N_LOG'(st + j);
          in_addr_v = N_LOG'(st + j + len / 2);
          in_addr_w = N_LOG'(j * (N / len));
          if (inject && n == 3) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_data = 16'd99;
          end else begin
            load_en = 1'b0;
          end
          tick();
          n++;
        end
    in_valid = 1'b0;
    load_en  = 1'b0;
    if (inject) chk("load_err_set", 32'(load_err), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    finish_run();
`ifdef NTT_EXEC_STATS_EN
    chk("bfly_cnt", 32'(bfly_cnt), 32'd12);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr_u = '0;
    in_addr_v = '0;
    in_addr_w = '0;
    in_done   = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    rd_addr   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_exec_done", 32'(exec_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_ram("rst_ram", vec_zero);

    // Transform of a delta is all ones
    load_vec(vec_delta);
    run_ntt(1'b0);
    chk_ram("t1_ram", vec_ones);

    // Transform of all ones concentrates at DC
    load_vec(vec_ones);
    run_ntt(1'b0);
    chk_ram("t2_ram", vec_dc);

    // Single beat; 20 is reduced to 3 on load
    load(0, 20);
    load(1, 5);
    rd_addr = 3'd0;
    #1;
    chk("t3_load_mod", 32'(rd_data), 32'd3);
    in_valid  = 1'b1;
    in_addr_u = 3'd0;
    in_addr_v = 3'd1;
    in_addr_w = 3'd0;
    tick();
    in_valid = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    rd_addr = 3'd0;
    #1;
    chk("t3_pre_wb", 32'(rd_data), 32'd3);
    tick();
    rd_addr = 3'd0;
    #1;
    chk("t3_u", 32'(rd_data), 32'd8);
    rd_addr = 3'd1;
    #1;
    chk("t3_v", 32'(rd_data), 32'd15);
    finish_run();

    // Back-to-back beats sharing index 0 exercise the bypass
    load(0, 3);
    load(1, 5);
    load(2, 1);
    load(3, 0);
    in_valid  = 1'b1;
    in_addr_u = 3'd0;
    in_addr_v = 3'd1;
    in_addr_w = 3'd0;
    tick();
    in_addr_u = 3'd0;
    in_addr_v = 3'd2;
    in_addr_w = 3'd1;
    tick();
    in_valid = 1'b0;
    tick();
    rd_addr = 3'd0;
    #1;
    chk("t4_ram0", 32'(rd_data), 32'd10);
    rd_addr = 3'd1;
    #1;
    chk("t4_ram1", 32'(rd_data), 32'd15);
    rd_addr = 3'd2;
    #1;
    chk("t4_ram2", 32'(rd_data), 32'd6);
    rd_addr = 3'd3;
    #1;
    chk("t4_ram3", 32'(rd_data), 32'd0);
    finish_run();

    // Host write while busy is dropped and flagged
    load_vec(vec_delta);
    run_ntt(1'b1);
    chk_ram("t5_ram", vec_ones);
    chk("t5_load_err_sticky", 32'(load_err), 32'd1);
    load(0, 7);
    rd_addr = 3'd0;
    #1;
    chk("t5_idle_load", 32'(rd_data), 32'd7);
    chk("t5_load_err_idle", 32'(load_err), 32'd1);

    // Asynchronous abort mid-run
    load_vec(vec_ones);
    in_valid  = 1'b1;
    in_addr_u = 3'd0;
    in_addr_v = 3'd1;
    in_addr_w = 3'd0;
    tick();
    in_addr_u = 3'd2;
    in_addr_v = 3'd3;
    tick();
    chk("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_exec_done", 32'(exec_done), 32'd0);
    chk("t6_load_err", 32'(load_err), 32'd0);
    chk_ram("t6_ram", vec_zero);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_ram("t6_ram_after", vec_zero);
    load_vec(vec_delta);
    run_ntt(1'b0);
    chk_ram("t6_rerun", vec_ones);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
